// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: counter sizing defaults and the modulus-exponent clamp.
package dpll_pkg;

    localparam int unsigned DPLL_K_MAX    = 6;
    localparam int unsigned DPLL_KSEL_MIN = 2;
    localparam int unsigned KSEL_W        = 3;
    localparam int unsigned KEFF_W        = 4;

    // Clamp the requested exponent into [kmin, kmax].
    function automatic logic [KEFF_W-1:0] keff(input logic [KSEL_W-1:0] ksel,
                                               input int unsigned kmin,
                                               input int unsigned kmax);
        int unsigned k;
        k = 32'(ksel);
        if (k < kmin) begin
            k = kmin;
        end else if (k > kmax) begin
            k = kmax;
        end
        return KEFF_W'(k);
    endfunction

endpackage

// File: rtl/modk_wrap_counter.sv
// Modulo-2^kEff counter that flags the step which wraps it back to zero.
module modk_wrap_counter
    import dpll_pkg::*;
#(
    parameter int unsigned K_MAX = DPLL_K_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    input  logic [KEFF_W-1:0] kEff,
    output logic [K_MAX-1:0]  count,
    output logic              wrap
);

    logic [K_MAX:0]   modulus;
    logic [K_MAX-1:0] top_val;
    logic [K_MAX-1:0] count_q;
    logic [K_MAX-1:0] count_d;

    assign modulus = (K_MAX+1)'(1) << kEff;
    assign top_val = K_MAX'(modulus - (K_MAX+1)'(1));

    // A clear discards the step in the same cycle, including its wrap.
    assign wrap  = step & ~clr & (count_q == top_val);
    assign count = count_q;

    // Next count: clear, wrap to zero, or increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (step) begin
            count_d = (count_q == top_val) ? '0 : count_q + K_MAX'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/k_counter_filter.sv
// Random-walk K-counter loop filter: integrates dnUp, emits paced inc/dec pulses.
module k_counter_filter
    import dpll_pkg::*;
#(
    parameter int unsigned K_MAX     = DPLL_K_MAX,
    parameter int unsigned KSEL_MIN  = DPLL_KSEL_MIN,
    parameter int unsigned PULSE_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              dnUp,
    input  logic [KSEL_W-1:0] kSel,
    output logic              incOut,
    output logic              decOut,
    output logic              dropped,
    output logic [K_MAX-1:0]  upCount,
    output logic [K_MAX-1:0]  downCount
);

    localparam int unsigned GAP_W = $clog2(PULSE_GAP + 1);

    logic [KEFF_W-1:0] k_eff;
    logic [KEFF_W-1:0] kprev_q;
    logic              k_chg;
    logic              carry_evt;
    logic              borrow_evt;
    logic              ready;
    logic              req_inc;
    logic              req_dec;
    logic              cancel;

    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             drop_q, drop_d;
    logic             inc_pend_q, inc_pend_d;
    logic             dec_pend_q, dec_pend_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    assign k_eff = keff(kSel, KSEL_MIN, K_MAX);
    assign k_chg = (k_eff != kprev_q);

    modk_wrap_counter #(
        .K_MAX (K_MAX)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .clr   (k_chg),
        .step  (enable & ~dnUp),
        .kEff  (k_eff),
        .count (upCount),
        .wrap  (carry_evt)
    );

    modk_wrap_counter #(
        .K_MAX (K_MAX)
    ) u_down (
        .clk   (clk),
        .reset (reset),
        .clr   (k_chg),
        .step  (enable & dnUp),
        .kEff  (k_eff),
        .count (downCount),
        .wrap  (borrow_evt)
    );

    assign ready   = (gap_q == '0);
    assign req_inc = carry_evt | inc_pend_q;
    assign req_dec = borrow_evt | dec_pend_q;
    // Opposing event against a pending pulse nets to zero phase.
    assign cancel  = (inc_pend_q & borrow_evt) | (dec_pend_q & carry_evt);

    // Pacing scheduler: issue, defer, drop or cancel pulses.
    always_comb begin
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        drop_d     = 1'b0;
        inc_pend_d = inc_pend_q;
        dec_pend_d = dec_pend_q;
        gap_d      = ready ? gap_q : gap_q - GAP_W'(1);
        if (cancel) begin
            inc_pend_d = 1'b0;
            dec_pend_d = 1'b0;
        end else if (ready && req_inc) begin
            inc_d      = 1'b1;
            inc_pend_d = 1'b0;
            gap_d      = GAP_W'(PULSE_GAP);
        end else if (ready && req_dec) begin
            dec_d      = 1'b1;
            dec_pend_d = 1'b0;
            gap_d      = GAP_W'(PULSE_GAP);
        end else if (!ready) begin
            if (carry_evt) begin
                if (inc_pend_q) drop_d = 1'b1;
                else            inc_pend_d = 1'b1;
            end
            if (borrow_evt) begin
                if (dec_pend_q) drop_d = 1'b1;
                else            dec_pend_d = 1'b1;
            end
        end
    end

    // Scheduler state, registered outputs and exponent tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            drop_q     <= 1'b0;
            inc_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
            gap_q      <= '0;
            kprev_q    <= k_eff;
        end else begin
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            drop_q     <= drop_d;
            inc_pend_q <= inc_pend_d;
            dec_pend_q <= dec_pend_d;
            gap_q      <= gap_d;
            kprev_q    <= k_eff;
        end
    end

    assign incOut  = inc_q;
    assign decOut  = dec_q;
    assign dropped = drop_q;

endmodule

// File: tb/tb_k_counter_filter.sv
// Directed bench: one instance with the default gap, one with PULSE_GAP=8.
module tb_k_counter_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       dnUp;
    logic [2:0] kSel;

    logic       a_inc, a_dec, a_drop;
    logic [5:0] a_up, a_dn;
    logic       b_inc, b_dec, b_drop;
    logic [5:0] b_up, b_dn;

    int total = 0;
    int bad   = 0;

    k_counter_filter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dnUp      (dnUp),
        .kSel      (kSel),
        .incOut    (a_inc),
        .decOut    (a_dec),
        .dropped   (a_drop),
        .upCount   (a_up),
        .downCount (a_dn)
    );

    k_counter_filter #(
        .PULSE_GAP (8)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dnUp      (dnUp),
        .kSel      (kSel),
        .incOut    (b_inc),
        .decOut    (b_dec),
        .dropped   (b_drop),
        .upCount   (b_up),
        .downCount (b_dn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] ks);
        kSel   = ks;
        enable = 1'b0;
        dnUp   = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd3);
        total++;
        if ({a_inc, a_dec, a_drop} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses got=%b exp=000", {a_inc, a_dec, a_drop});
        end
        total++;
        if (a_up !== 6'd0 || a_dn !== 6'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", a_up, a_dn);
        end
        total++;
        if ({b_inc, b_dec, b_drop, b_up, b_dn} !== 15'd0) begin
            bad++;
            $display("FAIL reset_gap8 got=%h exp=0", {b_inc, b_dec, b_drop, b_up, b_dn});
        end
    endtask

    // kSel=3: eight up steps give one carry pulse right after the 8th edge.
    task automatic test_single_carry();
        do_reset(3'd3);
        enable = 1'b1;
        dnUp   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (a_inc !== (i == 8)) begin
                bad++;
                $display("FAIL t1_inc edge=%0d got=%b exp=%b", i, a_inc, (i == 8));
            end
            total++;
            if (a_up !== 6'(i % 8)) begin
                bad++;
                $display("FAIL t1_up edge=%0d got=%0d exp=%0d", i, a_up, i % 8);
            end
            total++;
            if (a_dec !== 1'b0) begin
                bad++;
                $display("FAIL t1_dec edge=%0d got=%b exp=0", i, a_dec);
            end
        end
        enable = 1'b0;
        tick();
        total++;
        if (a_inc !== 1'b0 || a_up !== 6'd0) begin
            bad++;
            $display("FAIL t1_width got=%b/%0d exp=0/0", a_inc, a_up);
        end
    endtask

    // kSel=2, down held: borrow every 4 edges; gap 2 never drops. Then freeze.
    task automatic test_down_stream();
        do_reset(3'd2);
        enable = 1'b1;
        dnUp   = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            total++;
            if (a_dec !== (i % 4 == 0)) begin
                bad++;
                $display("FAIL t2_dec edge=%0d got=%b exp=%b", i, a_dec, (i % 4 == 0));
            end
            total++;
            if (a_drop !== 1'b0 || a_inc !== 1'b0) begin
                bad++;
                $display("FAIL t2_drop_inc edge=%0d got=%b%b exp=00", i, a_drop, a_inc);
            end
            total++;
            if (a_dn !== 6'(i % 4)) begin
                bad++;
                $display("FAIL t2_dn edge=%0d got=%0d exp=%0d", i, a_dn, i % 4);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (a_dn !== 6'd1 || a_dec !== 1'b0) begin
                bad++;
                $display("FAIL t2_freeze got=%0d/%b exp=1/0", a_dn, a_dec);
            end
        end
    endtask

    // Gap 8, carries every 4 edges: pulses at 4,13,22,31; drops at 12,20,28.
    task automatic test_pacing();
        logic exp_inc, exp_drop;
        do_reset(3'd2);
        enable = 1'b1;
        dnUp   = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_inc  = (i == 4) || (i == 13) || (i == 22) || (i == 31);
            exp_drop = (i == 12) || (i == 20) || (i == 28);
            total++;
            if (b_inc !== exp_inc) begin
                bad++;
                $display("FAIL t3_inc edge=%0d got=%b exp=%b", i, b_inc, exp_inc);
            end
            total++;
            if (b_drop !== exp_drop) begin
                bad++;
                $display("FAIL t3_drop edge=%0d got=%b exp=%b", i, b_drop, exp_drop);
            end
        end
    endtask

    // Gap 8: carry pulses at 7, next carry pends at 11, borrow at 12 cancels it.
    task automatic test_cancel();
        do_reset(3'd2);
        for (int i = 1; i <= 24; i++) begin
            dnUp   = (i <= 3) || (i == 12);
            enable = (i <= 12);
            tick();
            total++;
            if (b_inc !== (i == 7)) begin
                bad++;
                $display("FAIL t4_inc edge=%0d got=%b exp=%b", i, b_inc, (i == 7));
            end
            total++;
            if (b_dec !== 1'b0 || b_drop !== 1'b0) begin
                bad++;
                $display("FAIL t4_dec_drop edge=%0d got=%b%b exp=00", i, b_dec, b_drop);
            end
        end
        total++;
        if (b_dn !== 6'd0 || b_up !== 6'd0) begin
            bad++;
            $display("FAIL t4_counts got=%0d/%0d exp=0/0", b_up, b_dn);
        end
    endtask

    // Gap 8: a pending carry drains at edge 13 with the counters frozen.
    task automatic test_drain();
        do_reset(3'd2);
        enable = 1'b1;
        dnUp   = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        enable = 1'b0;
        for (int i = 9; i <= 15; i++) begin
            tick();
            total++;
            if (b_inc !== (i == 13) || b_up !== 6'd0) begin
                bad++;
                $display("FAIL drain edge=%0d got=%b/%0d exp=%b/0", i, b_inc, b_up, (i == 13));
            end
        end
    endtask

    // Gap 8: reset while a carry is pending kills it.
    task automatic test_reset_pending();
        do_reset(3'd2);
        enable = 1'b1;
        dnUp   = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({b_inc, b_dec, b_drop, b_up, b_dn} !== 15'd0) begin
            bad++;
            $display("FAIL t5_reset got=%h exp=0", {b_inc, b_dec, b_drop, b_up, b_dn});
        end
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            total++;
            if (b_inc !== 1'b0) begin
                bad++;
                $display("FAIL t5_no_pulse cyc=%0d got=%b exp=0", i, b_inc);
            end
        end
    endtask

    // kSel=7 clamps to 6 (wrap after 64); kSel 3->4 clears both counters.
    task automatic test_wide_and_change();
        do_reset(3'd7);
        enable = 1'b1;
        dnUp   = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            total++;
            if (a_inc !== (i == 64) || a_up !== 6'(i % 64)) begin
                bad++;
                $display("FAIL t6_wide edge=%0d got=%b/%0d exp=%b/%0d",
                         i, a_inc, a_up, (i == 64), i % 64);
            end
        end
        do_reset(3'd3);
        enable = 1'b1;
        dnUp   = 1'b1;
        tick();
        tick();
        dnUp = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (a_up !== 6'd5 || a_dn !== 6'd2) begin
            bad++;
            $display("FAIL t6_pre got=%0d/%0d exp=5/2", a_up, a_dn);
        end
        kSel = 3'd4;
        tick();
        total++;
        if (a_up !== 6'd0 || a_dn !== 6'd0 || a_inc !== 1'b0) begin
            bad++;
            $display("FAIL t6_clear got=%0d/%0d/%b exp=0/0/0", a_up, a_dn, a_inc);
        end
        tick();
        total++;
        if (a_up !== 6'd1) begin
            bad++;
            $display("FAIL t6_resume got=%0d exp=1", a_up);
        end
    endtask

    // kSel 0 and 1 both clamp to 2: switching between them must not clear.
    task automatic test_clamp_low();
        do_reset(3'd0);
        enable = 1'b1;
        dnUp   = 1'b0;
        tick();
        tick();
        kSel = 3'd1;
        tick();
        total++;
        if (a_up !== 6'd3 || a_inc !== 1'b0) begin
            bad++;
            $display("FAIL clamp_hold got=%0d/%b exp=3/0", a_up, a_inc);
        end
        tick();
        total++;
        if (a_up !== 6'd0 || a_inc !== 1'b1) begin
            bad++;
            $display("FAIL clamp_wrap got=%0d/%b exp=0/1", a_up, a_inc);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        dnUp   = 1'b0;
        kSel   = 3'd3;
        test_reset();
        test_single_carry();
        test_down_stream();
        test_pacing();
        test_cancel();
        test_drain();
        test_reset_pending();
        test_wide_and_change();
        test_clamp_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
